// File: rtl/masked_affine_pipe_if.sv
// Handshake and share bus for masked_affine_pipe.
// The slave modport is the pipe's view; the master modport is the driver's view.
interface masked_affine_pipe_if #(
  parameter int NIBBLES = 16
) ();
  localparam int W = 4 * NIBBLES;

  logic           in_valid;
  logic           in_ready;
  logic [1:0]     mode;
  logic [W-1:0]   x1;
  logic [W-1:0]   x2;
  logic [W-1:0]   x3;
  logic [2*W-1:0] rnd;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   y1;
  logic [W-1:0]   y2;
  logic [W-1:0]   y3;

  modport master (
    output in_valid, mode, x1, x2, x3, rnd, out_ready,
    input  in_ready, out_valid, y1, y2, y3
  );

  modport slave (
    input  in_valid, mode, x1, x2, x3, rnd, out_ready,
    output in_ready, out_valid, y1, y2, y3
  );
endinterface

// File: rtl/masked_affine_pipe.sv
// Pipelined 3-share masked affine layer for GIFT-style 4-bit S-box lanes.
// Stage 1 captures the affine result of each share (optionally re-masked with
// fresh randomness); further stages are plain stallable registers. Each share
// is processed on its own path and shares are never combined with each other.
module masked_affine_pipe #(
  parameter int NIBBLES = 16,
  parameter int STAGES  = 2,
  parameter int REFRESH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  masked_affine_pipe_if.slave bus
);
  localparam int W = 4 * NIBBLES;

  // Affine of one nibble; c is the constant injected into share 1 only.
  function automatic logic [3:0] affine_nib(input logic [3:0] x, input logic [1:0] m,
                                            input logic c);
    logic [3:0] o;
    case (m)
      2'd1:    o = {x[2] ^ x[1] ^ c, x[3] ^ x[0], x[0] ^ x[2] ^ c, x[1]};
      2'd2:    o = {x[3] ^ x[0] ^ c, x[2], x[3] ^ x[1], x[3] ^ c};
      default: o = x;  // identity, and reserved mode 3
    endcase
    return o;
  endfunction

  // Applies the nibble affine across all lanes of one share.
  function automatic logic [W-1:0] affine_vec(input logic [W-1:0] x, input logic [1:0] m,
                                              input logic c);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      v[4*i +: 4] = affine_nib(x[4*i +: 4], m, c);
    end
    return v;
  endfunction

  logic [W-1:0]        r1_s, r2_s;
  logic [W-1:0]        a1_s, a2_s, a3_s;
  logic [W-1:0]        s1_s, s2_s, s3_s;
  logic [STAGES-1:0]   load_s;
  logic                chain_s;
  logic [STAGES-1:0]   valid_d, valid_q;
  logic [W-1:0]        y1_d [STAGES];
  logic [W-1:0]        y2_d [STAGES];
  logic [W-1:0]        y3_d [STAGES];
  logic [W-1:0]        y1_q [STAGES];
  logic [W-1:0]        y2_q [STAGES];
  logic [W-1:0]        y3_q [STAGES];

  // Per-share affine followed by the optional share refresh for stage 1.
  always_comb begin
    r1_s = bus.rnd[W-1:0];
    r2_s = bus.rnd[2*W-1:W];
    a1_s = affine_vec(bus.x1, bus.mode, 1'b1);
    a2_s = affine_vec(bus.x2, bus.mode, 1'b0);
    a3_s = affine_vec(bus.x3, bus.mode, 1'b0);
    if (REFRESH != 0) begin
      s1_s = a1_s ^ r1_s;
      s2_s = a2_s ^ r2_s;
      s3_s = (a3_s ^ r1_s) ^ r2_s;
    end else begin
      s1_s = a1_s;
      s2_s = a2_s;
      s3_s = a3_s;
    end
  end

  // Combinational ready chain: a stage loads when empty or when it drains.
  always_comb begin
    load_s  = '0;
    chain_s = ~valid_q[STAGES-1] | bus.out_ready;
    load_s[STAGES-1] = chain_s;
    for (int k = STAGES - 2; k >= 0; k--) begin
      chain_s   = ~valid_q[k] | chain_s;
      load_s[k] = chain_s;
    end
  end

  assign bus.in_ready  = load_s[0];
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.y1        = y1_q[STAGES-1];
  assign bus.y2        = y2_q[STAGES-1];
  assign bus.y3        = y3_q[STAGES-1];

  // Next-state of every stage; vacated stages drop valid but keep their data.
  always_comb begin
    valid_d = valid_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    y3_d    = y3_q;
    if (load_s[0]) begin
      valid_d[0] = bus.in_valid;
      if (bus.in_valid) begin
        y1_d[0] = s1_s;
        y2_d[0] = s2_s;
        y3_d[0] = s3_s;
      end else begin
        y1_d[0] = y1_q[0];
        y2_d[0] = y2_q[0];
        y3_d[0] = y3_q[0];
      end
    end else begin
      valid_d[0] = valid_q[0];
    end
    for (int k = 1; k < STAGES; k++) begin
      if (load_s[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          y1_d[k] = y1_q[k-1];
          y2_d[k] = y2_q[k-1];
          y3_d[k] = y3_q[k-1];
        end else begin
          y1_d[k] = y1_q[k];
          y2_d[k] = y2_q[k];
          y3_d[k] = y3_q[k];
        end
      end else begin
        valid_d[k] = valid_q[k];
      end
    end
  end

  // Stage registers; reset discards all in-flight beats and zeroes the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        y1_q[k] <= '0;
        y2_q[k] <= '0;
        y3_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) begin
        y1_q[k] <= y1_d[k];
        y2_q[k] <= y2_d[k];
        y3_q[k] <= y3_d[k];
      end
    end
  end
endmodule

// File: tb/tb_masked_affine_pipe.sv
// Scoreboard bench for masked_affine_pipe: a small 1-lane unrefreshed instance
// for directed cases and a 16-lane, 3-stage refreshed instance for refresh,
// random traffic with stalls, and mid-stream reset.
module tb_masked_affine_pipe;
  typedef struct {
    logic [63:0] e1;
    logic [63:0] e2;
    logic [63:0] e3;
    logic [63:0] g;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q_s[$];
  exp_t q_b[$];
  logic acc_s = 1'b0;
  logic acc_b = 1'b0;
  int   n_acc_b = 0;

  always #5 clk = ~clk;

  masked_affine_pipe_if #(.NIBBLES(1))  ifs ();
  masked_affine_pipe_if #(.NIBBLES(16)) ifb ();

  masked_affine_pipe #(.NIBBLES(1), .STAGES(2), .REFRESH(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(ifs)
  );
  masked_affine_pipe #(.NIBBLES(16), .STAGES(3), .REFRESH(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Golden nibble-wise affine of one share (c = 1 for share 1 only).
  function automatic logic [63:0] aff_w(input logic [63:0] x, input int nib,
                                        input logic [1:0] m, input logic c);
    logic [63:0] o;
    logic [3:0]  n;
    logic [3:0]  r;
    o = '0;
    for (int i = 0; i < nib; i++) begin
      n = x[4*i +: 4];
      case (m)
        2'd1:    r = {n[2] ^ n[1] ^ c, n[3] ^ n[0], n[0] ^ n[2] ^ c, n[1]};
        2'd2:    r = {n[3] ^ n[0] ^ c, n[2], n[3] ^ n[1], n[3] ^ c};
        default: r = n;
      endcase
      o[4*i +: 4] = r;
    end
    return o;
  endfunction

  // Scoreboard for the small instance: push on accept, pop/compare on drain.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      acc_s = ifs.in_valid & ifs.in_ready;
      if (ifs.out_valid && ifs.out_ready) begin
        if (q_s.size() == 0) begin
          check_eq("s_unexpected_out", 64'd1, 64'd0);
        end else begin
          e = q_s.pop_front();
          check_eq("s_y1", {60'd0, ifs.y1}, e.e1);
          check_eq("s_y2", {60'd0, ifs.y2}, e.e2);
          check_eq("s_y3", {60'd0, ifs.y3}, e.e3);
        end
      end
      if (acc_s) begin
        e.e1 = aff_w({60'd0, ifs.x1}, 1, ifs.mode, 1'b1);
        e.e2 = aff_w({60'd0, ifs.x2}, 1, ifs.mode, 1'b0);
        e.e3 = aff_w({60'd0, ifs.x3}, 1, ifs.mode, 1'b0);
        e.g  = 64'd0;
        q_s.push_back(e);
      end
    end
  end

  // Scoreboard for the wide instance, with an unmasked golden cross-check.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      logic [63:0] r1;
      logic [63:0] r2;
      acc_b = ifb.in_valid & ifb.in_ready;
      if (ifb.out_valid && ifb.out_ready) begin
        if (q_b.size() == 0) begin
          check_eq("b_unexpected_out", 64'd1, 64'd0);
        end else begin
          e = q_b.pop_front();
          check_eq("b_y1", ifb.y1, e.e1);
          check_eq("b_y2", ifb.y2, e.e2);
          check_eq("b_y3", ifb.y3, e.e3);
          check_eq("b_unmasked", ifb.y1 ^ ifb.y2 ^ ifb.y3, e.g);
        end
      end
      if (acc_b) begin
        n_acc_b++;
        r1   = ifb.rnd[63:0];
        r2   = ifb.rnd[127:64];
        e.e1 = aff_w(ifb.x1, 16, ifb.mode, 1'b1) ^ r1;
        e.e2 = aff_w(ifb.x2, 16, ifb.mode, 1'b0) ^ r2;
        e.e3 = aff_w(ifb.x3, 16, ifb.mode, 1'b0) ^ r1 ^ r2;
        e.g  = aff_w(ifb.x1 ^ ifb.x2 ^ ifb.x3, 16, ifb.mode, 1'b1);
        q_b.push_back(e);
      end
    end
  end

  // Drive one beat into the small instance and wait (bounded) for acceptance.
  task automatic send_s(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c);
    logic acc;
    acc = 1'b0;
    ifs.mode = m; ifs.x1 = a; ifs.x2 = b; ifs.x3 = c; ifs.rnd = 8'd0;
    ifs.in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      acc = ifs.in_valid & ifs.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check_eq("s_accept_timeout", 64'd0, 64'd1);
    ifs.in_valid = 1'b0;
  endtask

  // Drive one beat into the wide instance and wait (bounded) for acceptance.
  task automatic send_b(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic [127:0] r);
    logic acc;
    acc = 1'b0;
    ifb.mode = m; ifb.x1 = a; ifb.x2 = b; ifb.x3 = c; ifb.rnd = r;
    ifb.in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      acc = ifb.in_valid & ifb.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check_eq("b_accept_timeout", 64'd0, 64'd1);
    ifb.in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #1500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int base;
    ifs.in_valid = 1'b0; ifs.mode = 2'd0; ifs.x1 = '0; ifs.x2 = '0; ifs.x3 = '0;
    ifs.rnd = '0; ifs.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.mode = 2'd0; ifb.x1 = '0; ifb.x2 = '0; ifb.x3 = '0;
    ifb.rnd = '0; ifb.out_ready = 1'b1;

    // Reset state while reset is held.
    #12;
    check_eq("rst_s_out_valid", {63'd0, ifs.out_valid}, 64'd0);
    check_eq("rst_s_y1", {60'd0, ifs.y1}, 64'd0);
    check_eq("rst_s_in_ready", {63'd0, ifs.in_ready}, 64'd1);
    check_eq("rst_b_out_valid", {63'd0, ifb.out_valid}, 64'd0);
    check_eq("rst_b_y", ifb.y1 | ifb.y2 | ifb.y3, 64'd0);
    check_eq("rst_b_in_ready", {63'd0, ifb.in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Mode A on all-zero shares: constant only in share 1, latency 2.
    send_s(2'd1, 4'h0, 4'h0, 4'h0);
    check_eq("t1_lat_early", {63'd0, ifs.out_valid}, 64'd0);
    tick();
    check_eq("t1_out_valid", {63'd0, ifs.out_valid}, 64'd1);
    check_eq("t1_y1", {60'd0, ifs.y1}, 64'hA);
    check_eq("t1_y2", {60'd0, ifs.y2}, 64'h0);
    check_eq("t1_y3", {60'd0, ifs.y3}, 64'h0);

    // Back-to-back beats with a mode change, no bubble.
    send_s(2'd1, 4'h5, 4'h0, 4'h0);
    send_s(2'd2, 4'h0, 4'h0, 4'h0);
    check_eq("t2_a_valid", {63'd0, ifs.out_valid}, 64'd1);
    check_eq("t2_a_y1", {60'd0, ifs.y1}, 64'h6);
    tick();
    check_eq("t2_b_valid", {63'd0, ifs.out_valid}, 64'd1);
    check_eq("t2_b_y1", {60'd0, ifs.y1}, 64'h9);
    tick();
    check_eq("t2_empty", {63'd0, ifs.out_valid}, 64'd0);

    // Backpressure: the pipe holds two beats, then refuses input.
    ifs.out_ready = 1'b0;
    send_s(2'd1, 4'h3, 4'h7, 4'hC);
    send_s(2'd2, 4'h9, 4'h1, 4'h4);
    check_eq("bp_full_ready", {63'd0, ifs.in_ready}, 64'd0);
    ifs.mode = 2'd0; ifs.x1 = 4'hF; ifs.x2 = 4'h2; ifs.x3 = 4'h8;
    ifs.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("bp_hold_ready", {63'd0, ifs.in_ready}, 64'd0);
      check_eq("bp_hold_valid", {63'd0, ifs.out_valid}, 64'd1);
      check_eq("bp_hold_y1", {60'd0, ifs.y1}, aff_w(64'h3, 1, 2'd1, 1'b1));
      check_eq("bp_hold_y3", {60'd0, ifs.y3}, aff_w(64'hC, 1, 2'd1, 1'b0));
    end
    ifs.out_ready = 1'b1;
    #1;
    check_eq("bp_ready_comb", {63'd0, ifs.in_ready}, 64'd1);
    send_s(2'd0, 4'hF, 4'h2, 4'h8);
    send_s(2'd3, 4'h6, 4'h6, 4'h1);
    repeat (6) tick();
    check_eq("bp_drained", q_s.size(), 64'd0);

    // Refresh with fixed randomness on the wide, 3-stage instance.
    send_b(2'd1, 64'd0, 64'd0, 64'd0, {{16{4'h5}}, {16{4'h3}}});
    check_eq("t3_lat1", {63'd0, ifb.out_valid}, 64'd0);
    tick();
    check_eq("t3_lat2", {63'd0, ifb.out_valid}, 64'd0);
    tick();
    check_eq("t3_valid", {63'd0, ifb.out_valid}, 64'd1);
    check_eq("t3_y1", ifb.y1, {16{4'h9}});
    check_eq("t3_y2", ifb.y2, {16{4'h5}});
    check_eq("t3_y3", ifb.y3, {16{4'h6}});
    check_eq("t3_xor", ifb.y1 ^ ifb.y2 ^ ifb.y3, {16{4'hA}});
    tick();

    // Random traffic with random stalls on both sides.
    base = n_acc_b;
    for (int cyc = 0; cyc < 60000 && n_acc_b < base + 10000; cyc++) begin
      if (acc_b || !ifb.in_valid) begin
        ifb.mode  = 2'($urandom_range(0, 3));
        ifb.x1    = {$urandom, $urandom};
        ifb.x2    = {$urandom, $urandom};
        ifb.x3    = {$urandom, $urandom};
        ifb.rnd   = {$urandom, $urandom, $urandom, $urandom};
        ifb.in_valid = (n_acc_b < base + 9999 || !acc_b) && ($urandom_range(0, 3) != 0);
      end
      ifb.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    ifb.in_valid = 1'b0;
    ifb.out_ready = 1'b1;
    repeat (8) tick();
    check_eq("rand_beats", (n_acc_b - base >= 10000) ? 64'd1 : 64'd0, 64'd1);
    check_eq("rand_drained", q_b.size(), 64'd0);

    // Mid-stream reset with a full pipe.
    ifb.out_ready = 1'b0;
    send_b(2'd2, 64'h1111, 64'h2222, 64'h3333, 128'h55);
    send_b(2'd1, 64'h4444, 64'h5555, 64'h6666, 128'h66);
    send_b(2'd0, 64'h7777, 64'h8888, 64'h9999, 128'h77);
    check_eq("rs_full", {63'd0, ifb.in_ready}, 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rs_out_valid", {63'd0, ifb.out_valid}, 64'd0);
    check_eq("rs_y", ifb.y1 | ifb.y2 | ifb.y3, 64'd0);
    check_eq("rs_in_ready", {63'd0, ifb.in_ready}, 64'd1);
    q_b.delete();
    q_s.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ifb.out_ready = 1'b1;
    tick();
    send_b(2'd1, 64'hDEAD_BEEF_0123_4567, 64'h0F0F, 64'hF0F0, {64'h1234, 64'h5678});
    check_eq("rs_lat1", {63'd0, ifb.out_valid}, 64'd0);
    tick();
    check_eq("rs_lat2", {63'd0, ifb.out_valid}, 64'd0);
    tick();
    check_eq("rs_lat3", {63'd0, ifb.out_valid}, 64'd1);
    tick();
    check_eq("rs_single", {63'd0, ifb.out_valid}, 64'd0);
    check_eq("rs_drained", q_b.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
